// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART receive path
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int DEF_DATA_BITS  = 8;
   localparam int DEF_OVERSAMPLE = 16;

   // Tick index that lands in the middle of a bit period.
   localparam int MID_SAMPLE = DEF_OVERSAMPLE / 2 - 1;

   function automatic int mid_sample(input int oversample);
      return oversample / 2 - 1;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver line-side and host-side handshake signals
interface uart_rx_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS
);

   logic                 tick;
   logic                 rx;
   logic                 rd;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 frame_err;
   logic                 overrun;

   modport master (
      output tick,
      output rx,
      output rd,
      input  data_out,
      input  data_valid,
      input  frame_err,
      input  overrun
   );

   modport slave (
      input  tick,
      input  rx,
      input  rd,
      output data_out,
      output data_valid,
      output frame_err,
      output overrun
   );

endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an idle-high asynchronous line
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Reset to 1 so a line in reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 receiver with one-entry output register
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.slave  bus
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int NW = $clog2(DATA_BITS);

   localparam logic [SW-1:0] S_MID  = SW'(mid_sample(OVERSAMPLE));
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

   logic rx_s;

   state_t               state_q, state_d;
   logic [SW-1:0]        s_cnt_q, s_cnt_d;
   logic [NW-1:0]        n_cnt_q, n_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] data_q,  data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q,  ferr_d;
   logic                 ovr_q,   ovr_d;

   uart_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.rx),
      .q   (rx_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         s_cnt_q <= '0;
         n_cnt_q <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_cnt_q <= s_cnt_d;
         n_cnt_q <= n_cnt_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_cnt_d = s_cnt_q;
      n_cnt_d = n_cnt_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;

      // A host read drops valid unless a completing frame overrides it below.
      if (bus.rd) begin
         valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               s_cnt_d = '0;
            end
         end

         START: begin
            if (bus.tick) begin
               if (s_cnt_q == S_MID) begin
                  s_cnt_d = '0;
                  if (!rx_s) begin
                     state_d = DATA;
                     n_cnt_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SW'(1);
               end
            end
         end

         DATA: begin
            if (bus.tick) begin
               if (s_cnt_q == S_LAST) begin
                  s_cnt_d = '0;
                  shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                  if (n_cnt_q == N_LAST) begin
                     state_d = STOP;
                  end else begin
                     n_cnt_d = n_cnt_q + NW'(1);
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SW'(1);
               end
            end
         end

         STOP: begin
            if (bus.tick) begin
               if (s_cnt_q == S_LAST) begin
                  s_cnt_d = '0;
                  state_d = IDLE;
                  if (rx_s) begin
                     data_d  = shreg_q;
                     valid_d = 1'b1;
                     if (valid_q && !bus.rd) begin
                        ovr_d = 1'b1;
                     end
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SW'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.data_out   = data_q;
   assign bus.data_valid = valid_q;
   assign bus.frame_err  = ferr_q;
   assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized scoreboard bench for uart_rx
module tb_uart_rx;
   import uart_pkg::*;

   localparam int BIT_CLK = 64;

   logic clk = 1'b0;
   logic rst;

   uart_rx_if bus ();

   uart_rx dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] exp_q[$];
   logic [7:0] last_good;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Oversample strobe: one clk high out of every four.
   initial begin
      bus.tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         bus.tick = 1'b1;
         @(negedge clk);
         bus.tick = 1'b0;
      end
   end

   // Monitor: a newly presented byte is either a valid rise or a data change while valid.
   initial begin : monitor
      logic       prev_valid;
      logic [7:0] prev_data;
      logic [7:0] e;
      prev_valid = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (bus.data_valid && (!prev_valid || bus.data_out != prev_data)) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", bus.data_out, $time);
            end else begin
               e = exp_q.pop_front();
               check("rx_byte", 32'(bus.data_out), 32'(e));
            end
         end
         prev_valid = bus.data_valid;
         prev_data  = bus.data_out;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Line-level frame: start, LSB-first data, stop; good frames feed the scoreboard.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      if (stop) begin
         exp_q.push_back(b);
      end
      bus.rx = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      bus.rx = stop;
      repeat (BIT_CLK) @(negedge clk);
      bus.rx = 1'b1;
   endtask

   task automatic pulse_rd();
      bus.rd = 1'b1;
      @(negedge clk);
      bus.rd = 1'b0;
   endtask

   task automatic check_flags(input string tag, input logic ferr, input logic ovr);
      check({tag, "_frame_err"}, 32'(bus.frame_err), 32'(ferr));
      check({tag, "_overrun"},   32'(bus.overrun),   32'(ovr));
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] pat;
      rst    = 1'b1;
      bus.rx = 1'b1;
      bus.rd = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_data_out", 32'(bus.data_out), 32'h0);
      check("reset_valid",    32'(bus.data_valid), 32'h0);
      check_flags("reset", 1'b0, 1'b0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Single clean frame and a read.
      send_frame(8'h55, 1'b1);
      check("s1_valid", 32'(bus.data_valid), 32'h1);
      check("s1_data",  32'(bus.data_out),   32'h55);
      check_flags("s1", 1'b0, 1'b0);
      pulse_rd();
      check("s1_rd_clears", 32'(bus.data_valid), 32'h0);

      // Back-to-back frames, read during the second.
      send_frame(8'hA3, 1'b1);
      fork
         send_frame(8'h0F, 1'b1);
         begin
            repeat (4) @(negedge clk);
            check("s2_valid_a3", 32'(bus.data_valid), 32'h1);
            check("s2_data_a3",  32'(bus.data_out),   32'hA3);
            pulse_rd();
            check("s2_rd_a3", 32'(bus.data_valid), 32'h0);
         end
      join
      check("s2_valid_0f", 32'(bus.data_valid), 32'h1);
      check("s2_data_0f",  32'(bus.data_out),   32'h0F);
      pulse_rd();
      check("s2_rd_0f", 32'(bus.data_valid), 32'h0);
      check_flags("s2", 1'b0, 1'b0);
      last_good = 8'h0F;

      // Short low glitch must not start a frame.
      bus.rx = 1'b0;
      repeat (20) @(negedge clk);
      bus.rx = 1'b1;
      repeat (2 * BIT_CLK) @(negedge clk);
      check("s3_valid", 32'(bus.data_valid), 32'h0);
      check_flags("s3", 1'b0, 1'b0);

      // Random clean frames with random idle gaps.
      for (int n = 0; n < 8; n++) begin
         repeat ($urandom_range(0, 100)) @(negedge clk);
         b = 8'($urandom);
         send_frame(b, 1'b1);
         check("rand_valid", 32'(bus.data_valid), 32'h1);
         check("rand_data",  32'(bus.data_out),   32'(b));
         pulse_rd();
         check("rand_rd", 32'(bus.data_valid), 32'h0);
         check_flags("rand", 1'b0, 1'b0);
         last_good = b;
      end

      // Low stop bit: framing error, output register untouched.
      send_frame(8'hFF, 1'b0);
      repeat (BIT_CLK) @(negedge clk);
      check("s4_frame_err", 32'(bus.frame_err),  32'h1);
      check("s4_valid",     32'(bus.data_valid), 32'h0);
      check("s4_data_kept", 32'(bus.data_out),   32'(last_good));
      check("s4_overrun",   32'(bus.overrun),    32'h0);

      // Two good frames without a read: overrun.
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      check("s5_data",  32'(bus.data_out),   32'h22);
      check("s5_valid", 32'(bus.data_valid), 32'h1);
      check_flags("s5", 1'b1, 1'b1);

      // Reset mid-DATA after three bits of 0x5A.
      pat    = 8'h5A;
      bus.rx = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         bus.rx = pat[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      #2 rst = 1'b1;
      #1;
      check("s6_async_data",  32'(bus.data_out),   32'h0);
      check("s6_async_valid", 32'(bus.data_valid), 32'h0);
      check_flags("s6_async", 1'b0, 1'b0);
      @(negedge clk);
      bus.rx = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      send_frame(pat, 1'b1);
      check("s6_valid", 32'(bus.data_valid), 32'h1);
      check("s6_data",  32'(bus.data_out),   32'h5A);
      check_flags("s6", 1'b0, 1'b0);
      pulse_rd();
      repeat (BIT_CLK) @(negedge clk);

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
